// File: rtl/softmax_requant_sink.sv
// Softmax output sink: requantises Q16.16 probability tiles to unsigned Q0.OUT_WIDTH,
// tags the last tile of each row and buffers tiles for the attention*V stage.
module softmax_requant_sink #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned FRAC_WIDTH     = 16,
    parameter int unsigned OUT_WIDTH      = 16,
    parameter int unsigned TILE_SIZE      = 8,
    parameter int unsigned TOTAL_ELEMENTS = 64,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [TILE_SIZE*WIDTH-1:0]     Y_tile_in,
    input  logic                           tile_in_valid,
    input  logic                           row_done_in,
    output logic [TILE_SIZE*OUT_WIDTH-1:0] P_tile_out,
    output logic                           tile_out_valid,
    input  logic                           tile_out_ready,
    output logic                           tile_out_last,
    output logic                           overflow_err,
    output logic                           count_err,
    output logic                           busy
);

    localparam int unsigned NT     = TOTAL_ELEMENTS / TILE_SIZE;
    localparam int unsigned TC_W   = (NT > 1) ? $clog2(NT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OW     = TILE_SIZE * OUT_WIDTH;
    localparam int unsigned SH     = FRAC_WIDTH - OUT_WIDTH;
    localparam int unsigned SH_M1  = (SH > 0) ? SH - 1 : 0;
    localparam logic [WIDTH:0] RND = (SH > 0) ? ((WIDTH+1)'(1) << SH_M1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_ROW, S_DRAIN} state_e;

    // Round half up, clamp negatives to zero and saturate values >= 1.0.
    function automatic logic [OUT_WIDTH-1:0] conv_elem(input logic [WIDTH-1:0] x);
        logic [WIDTH:0]         sum;
        logic [WIDTH:0]         r;
        logic [OUT_WIDTH-1:0]   res;
        sum = {1'b0, x} + RND;
        r   = sum >> SH;
        res = r[OUT_WIDTH-1:0];
        if (x[WIDTH-1]) begin
            res = '0;
        end else if ((r >> OUT_WIDTH) != '0) begin
            res = '1;
        end
        return res;
    endfunction

    state_e                 state_q, state_d;
    logic [TC_W-1:0]        tc_q, tc_d, tc_upd;
    logic                   stage_valid_q, stage_valid_d;
    logic [OW-1:0]          stage_data_q, stage_data_d;
    logic                   stage_last_q, stage_last_d;
    logic [OW:0]            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d, count_after_pop;
    logic                   out_valid_q, out_valid_d;
    logic [OW-1:0]          out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic                   ovf_q, ovf_d, cerr_q, cerr_d;
    logic [OW-1:0]          conv_tile;
    logic                   tile_acc, row_done, in_last, pop, can_move, push;
    logic                   stage_free, capture, drop, cnt_evt;

    // Convert every element of the incoming tile in parallel.
    always_comb begin
        conv_tile = '0;
        for (int i = 0; i < int'(TILE_SIZE); i++) begin
            conv_tile[i*OUT_WIDTH +: OUT_WIDTH] = conv_elem(Y_tile_in[i*WIDTH +: WIDTH]);
        end
    end

    // Datapath next-state: stage register, FIFO pointers, output head, counters, flags.
    always_comb begin
        tile_acc   = en && tile_in_valid;
        row_done   = en && row_done_in;
        in_last    = (tc_q == TC_W'(NT - 1));
        pop        = out_valid_q && tile_out_ready;
        can_move   = (count_q != CNT_W'(FIFO_DEPTH)) || pop;
        push       = stage_valid_q && can_move;
        stage_free = !stage_valid_q || can_move;
        capture    = tile_acc && stage_free;
        drop       = tile_acc && !stage_free;

        stage_valid_d = stage_valid_q;
        stage_data_d  = stage_data_q;
        stage_last_d  = stage_last_q;
        if (push) begin
            stage_valid_d = 1'b0;
        end
        if (capture) begin
            stage_valid_d = 1'b1;
            stage_data_d  = conv_tile;
            stage_last_d  = in_last;
        end

        rd_ptr_d        = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d        = wr_ptr_q + PTR_W'(push);
        count_after_pop = count_q - CNT_W'(pop);
        count_d         = count_after_pop + CNT_W'(push);

        out_valid_d = (count_d != '0);
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (push && (count_after_pop == '0)) begin
            out_data_d = stage_data_q;
            out_last_d = stage_last_q;
        end else if (count_after_pop != '0) begin
            out_data_d = mem_q[rd_ptr_d][OW-1:0];
            out_last_d = mem_q[rd_ptr_d][OW];
        end

        tc_upd = tc_q;
        if (tile_acc) begin
            tc_upd = in_last ? '0 : tc_q + TC_W'(1);
        end
        cnt_evt = row_done && (tc_upd != '0);
        tc_d    = cnt_evt ? '0 : tc_upd;

        ovf_d  = ovf_q || drop;
        cerr_d = cerr_q || cnt_evt;
    end

    // Row-tracking FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ROW: begin
                if (tile_acc) begin
                    state_d = in_last ? S_DRAIN : S_ROW;
                end
            end
            S_DRAIN: begin
                if (tile_acc) begin
                    state_d = in_last ? S_DRAIN : S_ROW;
                end else if (!stage_valid_q && (count_q == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (cnt_evt) begin
            state_d = (!stage_valid_d && (count_d == '0)) ? S_IDLE : S_DRAIN;
        end
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tc_q          <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            stage_last_q  <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            ovf_q         <= 1'b0;
            cerr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tc_q          <= tc_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            stage_last_q  <= stage_last_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            ovf_q         <= ovf_d;
            cerr_q        <= cerr_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {stage_last_q, stage_data_q};
        end
    end

    assign P_tile_out     = out_data_q;
    assign tile_out_valid = out_valid_q;
    assign tile_out_last  = out_last_q;
    assign overflow_err   = ovf_q;
    assign count_err      = cerr_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_softmax_requant_sink.sv
// Directed bench for softmax_requant_sink: conversion tables plus row/FIFO corner sequences.
module tb_softmax_requant_sink;

    logic         clk, rst, en, tile_in_valid, row_done_in, tile_out_ready;
    logic [255:0] Y_tile_in;
    logic [127:0] p0;
    logic [63:0]  p1;
    logic         v0, l0, ovf0, cerr0, busy0;
    logic         v1, l1, ovf1, cerr1, busy1;

    int checks = 0;
    int failures = 0;
    int tags[$];
    bit lasts[$];

    softmax_requant_sink u0 (
        .clk(clk), .rst(rst), .en(en), .Y_tile_in(Y_tile_in),
        .tile_in_valid(tile_in_valid), .row_done_in(row_done_in),
        .P_tile_out(p0), .tile_out_valid(v0), .tile_out_ready(tile_out_ready),
        .tile_out_last(l0), .overflow_err(ovf0), .count_err(cerr0), .busy(busy0)
    );

    softmax_requant_sink #(.OUT_WIDTH(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .Y_tile_in(Y_tile_in),
        .tile_in_valid(tile_in_valid), .row_done_in(row_done_in),
        .P_tile_out(p1), .tile_out_valid(v1), .tile_out_ready(tile_out_ready),
        .tile_out_last(l1), .overflow_err(ovf1), .count_err(cerr1), .busy(busy1)
    );

    typedef struct {
        logic [31:0] x;
        logic [15:0] p16;
        logic [7:0]  p8;
    } conv_vec_t;

    conv_vec_t cv[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every tile popped from the 16-bit instance (tag = element 0).
    always @(posedge clk) begin
        if (!rst && v0 && tile_out_ready) begin
            tags.push_back(int'(p0[127:112]));
            lasts.push_back(l0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] uni(input int v);
        logic [255:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) y[i*32 +: 32] = 32'(v);
        return y;
    endfunction

    task automatic send(input int tag);
        tile_in_valid = 1'b1;
        Y_tile_in     = uni(tag);
        tick();
        tile_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tile_in_valid = 1'b0;
        row_done_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tags.delete();
        lasts.delete();
    endtask

    task automatic wait_pops(input int n);
        int cyc;
        cyc = 0;
        while (tags.size() < n && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("pop_count", 64'(tags.size()), 64'(n));
    endtask

    task automatic chk_seq(input string name, input int exp_tags[$], input int last_idx);
        for (int i = 0; i < exp_tags.size(); i++) begin
            if (i < tags.size()) begin
                chk({name, "_tag"}, 64'(tags[i]), 64'(exp_tags[i]));
                chk({name, "_last"}, 64'(lasts[i]), 64'(i == last_idx));
            end
        end
    endtask

    initial begin
        logic [255:0] ya, yb;
        int exp_q[$];

        cv[0]  = '{32'h0000_8000, 16'h8000, 8'h80};
        cv[1]  = '{32'h0001_0000, 16'hFFFF, 8'hFF};
        cv[2]  = '{32'hFFFF_0000, 16'h0000, 8'h00};
        cv[3]  = '{32'h0000_FFFF, 16'hFFFF, 8'hFF};
        cv[4]  = '{32'h0000_0000, 16'h0000, 8'h00};
        cv[5]  = '{32'h0000_3333, 16'h3333, 8'h33};
        cv[6]  = '{32'h0002_0000, 16'hFFFF, 8'hFF};
        cv[7]  = '{32'h0000_0001, 16'h0001, 8'h00};
        cv[8]  = '{32'h0000_0080, 16'h0080, 8'h01};
        cv[9]  = '{32'h0000_007F, 16'h007F, 8'h00};
        cv[10] = '{32'h0000_FF80, 16'hFF80, 8'hFF};
        cv[11] = '{32'h0000_0180, 16'h0180, 8'h02};
        cv[12] = '{32'h0000_1234, 16'h1234, 8'h12};
        cv[13] = '{32'h0000_7F7F, 16'h7F7F, 8'h7F};
        cv[14] = '{32'h8000_0000, 16'h0000, 8'h00};
        cv[15] = '{32'h0001_0001, 16'hFFFF, 8'hFF};

        en = 1'b1;
        tile_out_ready = 1'b0;
        Y_tile_in = '0;
        do_reset();

        // Reset state.
        chk("rst_valid", 64'(v0), 64'(0));
        chk("rst_data", 64'(p0), 64'(0));
        chk("rst_last", 64'(l0), 64'(0));
        chk("rst_ovf", 64'(ovf0), 64'(0));
        chk("rst_cerr", 64'(cerr0), 64'(0));
        chk("rst_busy", 64'(busy0), 64'(0));

        // Conversion tables, two tiles back to back, both output widths.
        for (int i = 0; i < 8; i++) begin
            ya[(7-i)*32 +: 32] = cv[i].x;
            yb[(7-i)*32 +: 32] = cv[8+i].x;
        end
        tile_out_ready = 1'b1;
        tile_in_valid = 1'b1;
        Y_tile_in = ya;
        tick();
        Y_tile_in = yb;
        chk("lat_valid_early", 64'(v0), 64'(0));
        tick();
        tile_in_valid = 1'b0;
        chk("lat_valid_2cyc", 64'(v0), 64'(1));
        for (int i = 0; i < 8; i++) begin
            chk("conv16_a", 64'(p0[(7-i)*16 +: 16]), 64'(cv[i].p16));
            chk("conv8_a", 64'(p1[(7-i)*8 +: 8]), 64'(cv[i].p8));
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("conv16_b", 64'(p0[(7-i)*16 +: 16]), 64'(cv[8+i].p16));
            chk("conv8_b", 64'(p1[(7-i)*8 +: 8]), 64'(cv[8+i].p8));
        end

        // Full row, ready held high.
        do_reset();
        tile_out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) send(k);
        chk("row_busy", 64'(busy0), 64'(1));
        wait_pops(8);
        exp_q = {1, 2, 3, 4, 5, 6, 7, 8};
        chk_seq("row", exp_q, 7);
        tick();
        chk("row_busy_fall", 64'(busy0), 64'(0));
        row_done_in = 1'b1;
        tick();
        row_done_in = 1'b0;
        chk("row_cerr", 64'(cerr0), 64'(0));
        chk("row_ovf", 64'(ovf0), 64'(0));

        // Backpressure: 4 in FIFO, 5th in stage, 6th dropped.
        do_reset();
        tile_out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send(k);
        chk("bp_ovf_before", 64'(ovf0), 64'(0));
        send(6);
        chk("bp_ovf_after", 64'(ovf0), 64'(1));
        tick();
        tick();
        chk("bp_hold_valid", 64'(v0), 64'(1));
        chk("bp_hold_tag", 64'(p0[127:112]), 64'(1));
        tile_out_ready = 1'b1;
        wait_pops(5);
        exp_q = {1, 2, 3, 4, 5};
        chk_seq("bp", exp_q, -1);
        tick();
        tick();
        chk("bp_empty", 64'(v0), 64'(0));

        // Mid-row reset clears everything, including the sticky overflow.
        tags.delete();
        lasts.delete();
        tile_out_ready = 1'b0;
        send(1);
        send(2);
        send(3);
        rst = 1'b1;
        tile_in_valid = 1'b1;
        Y_tile_in = uni(4);
        tick();
        rst = 1'b0;
        tile_in_valid = 1'b0;
        chk("mrst_valid", 64'(v0), 64'(0));
        chk("mrst_data", 64'(p0), 64'(0));
        chk("mrst_busy", 64'(busy0), 64'(0));
        chk("mrst_ovf", 64'(ovf0), 64'(0));
        tick();
        tick();
        chk("mrst_empty", 64'(v0), 64'(0));
        tags.delete();
        lasts.delete();
        tile_out_ready = 1'b1;
        for (int k = 21; k <= 28; k++) send(k);
        wait_pops(8);
        exp_q = {21, 22, 23, 24, 25, 26, 27, 28};
        chk_seq("mrst", exp_q, 7);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        tile_out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send(k);
        tile_out_ready = 1'b1;
        send(6);
        send(7);
        send(8);
        wait_pops(8);
        exp_q = {1, 2, 3, 4, 5, 6, 7, 8};
        chk_seq("pp", exp_q, 7);
        chk("pp_ovf", 64'(ovf0), 64'(0));

        // row_done after 3 tiles, then a clean row.
        do_reset();
        tile_out_ready = 1'b1;
        send(1);
        send(2);
        send(3);
        row_done_in = 1'b1;
        tick();
        row_done_in = 1'b0;
        chk("mrd_cerr", 64'(cerr0), 64'(1));
        for (int k = 11; k <= 18; k++) send(k);
        wait_pops(11);
        exp_q = {1, 2, 3, 11, 12, 13, 14, 15, 16, 17, 18};
        chk_seq("mrd", exp_q, 10);
        tick();
        tick();
        chk("mrd_cerr_sticky", 64'(cerr0), 64'(1));
        chk("mrd_ovf", 64'(ovf0), 64'(0));
        chk("mrd_idle", 64'(busy0), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
